fetch_buffer: RTL and testbench

Instruction-fetch front end between a variable-latency instruction memory (req/ack handshake) and the pipeline's IF/ID boundary. It generates sequential fetch addresses, keeps at most one memory request in flight, and queues returned {PC, instruction} pairs in a small FIFO. It presents the FIFO head to the decode register and handles branch/jump redirects from EX, including discarding a response that is already in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer_if.sv | 23 ++
 rtl/fetch_fifo.sv | 43 ++++
 rtl/fetch_buffer.sv | 122 ++++++++++++
 tb/tb_fetch_buffer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction memory req/ack bus between fetch and memory
interface fetch_buffer_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of {pc, instr} pairs with single-cycle flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch address generator, one-outstanding memory FSM and decode-facing FIFO head
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCSrcE,
  input  logic [31:0]           PCTargetE,
  input  logic                  StallD,
  fetch_buffer_if.master        mem,
  output logic [31:0]           InstrF,
  output logic [31:0]           PCF,
  output logic [31:0]           PCPlus4F,
  output logic                  InstrValidF,
  output logic                  FetchStall
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_pc;
  logic [31:0]   req_addr;
  logic          req_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          ack;
  logic          push;
  logic          pop;
  logic [31:0]   resume_pc;

  // An ack is only meaningful while our own request is on the bus
  assign ack        = mem.mem_ack & req_q;
  assign pop        = InstrValidF & ~StallD & ~PCSrcE;
  assign push       = ack & ~PCSrcE & (state == REQ);
  assign count_next = count + CW'(push) - CW'(pop);
  assign resume_pc  = PCSrcE ? PCTargetE : redirect_pc;
  assign push_entry = '{pc: fetch_pc, instr: mem.mem_rdata};

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = req_addr;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (PCSrcE),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
      req_addr    <= RESET_PC;
      req_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PCSrcE) begin
            fetch_pc <= PCTargetE;
            req_addr <= PCTargetE;
            req_q    <= 1'b1;
            state    <= REQ;
          end else if (count < FULL) begin
            req_addr <= fetch_pc;
            req_q    <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (PCSrcE && ack) begin
            fetch_pc <= PCTargetE;
            req_addr <= PCTargetE;
          end else if (PCSrcE) begin
            // The old request must still complete; its data is dropped
            redirect_pc <= PCTargetE;
            state       <= DISCARD;
          end else if (ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next < FULL) begin
              req_addr <= fetch_pc + 32'd4;
            end else begin
              req_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (ack) begin
            fetch_pc <= resume_pc;
            req_addr <= resume_pc;
            state    <= REQ;
          end else if (PCSrcE) begin
            redirect_pc <= PCTargetE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign InstrValidF = (count != '0);
  assign FetchStall  = ~InstrValidF;
  assign InstrF      = InstrValidF ? head.instr : NOP_INSTR;
  assign PCF         = InstrValidF ? head.pc : 32'd0;
  assign PCPlus4F    = PCF + 32'd4;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer with a variable-latency memory model
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        StallD = 1'b0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;
  logic        FetchStall;

  fetch_buffer_if mem ();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .StallD      (StallD),
    .mem         (mem),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .InstrValidF (InstrValidF),
    .FetchStall  (FetchStall)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  fetch_entry_t sb[$];
  int           lat = 0;
  bit           mem_en = 1'b1;
  bit           force_ack = 1'b0;
  bit           busy = 1'b0;
  bit           tainted = 1'b0;
  bit           req_new = 1'b0;
  int           wait_cnt = 0;
  logic [31:0]  req_addr = 32'd0;
  logic [31:0]  exp_pc = 32'd0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Memory model and scoreboard share one process so their state has a single writer
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      req_new = 1'b0;
      if (mem_en) begin
        if (!busy && mem.mem_req) begin
          busy     = 1'b1;
          wait_cnt = lat;
          req_addr = mem.mem_addr;
          tainted  = 1'b0;
          req_new  = 1'b1;
        end else if (busy) begin
          check("addr_hold", mem.mem_addr, req_addr);
        end
        if (busy && wait_cnt == 0) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = instr_of(req_addr);
        end else begin
          mem.mem_ack   = 1'b0;
          mem.mem_rdata = 32'd0;
          if (busy) wait_cnt--;
        end
      end else begin
        mem.mem_ack   = force_ack;
        mem.mem_rdata = 32'hDEAD_BEEF;
      end

      @(negedge clk);
      if (reset) begin
        sb.delete();
        busy   = 1'b0;
        exp_pc = 32'd0;
      end else begin
        check("valid_vs_sb", 32'(InstrValidF), 32'(sb.size() != 0));
        check("fetchstall", 32'(FetchStall), 32'(sb.size() == 0));
        if (InstrValidF && !StallD && !PCSrcE) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            fetch_entry_t e;
            e = sb.pop_front();
            check("pcf", PCF, e.pc);
            check("instr", InstrF, e.instr);
            check("pcplus4", PCPlus4F, e.pc + 32'd4);
            check("pc_seq", e.pc, exp_pc);
            exp_pc = e.pc + 32'd4;
          end
        end
        if (PCSrcE) begin
          sb.delete();
          exp_pc = PCTargetE;
          if (busy) tainted = 1'b1;
        end
        if (busy && mem.mem_ack) begin
          if (!tainted) sb.push_back('{pc: req_addr, instr: instr_of(req_addr)});
          busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    PCSrcE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string tag);
    int t = 0;
    while (!(req_new && mem.mem_addr == a) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(req_new && mem.mem_addr == a)) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_addr_change(input logic [31:0] old_a, input logic [31:0] exp_a, input string tag);
    int t = 0;
    while (mem.mem_addr == old_a && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(tag, mem.mem_addr, exp_a);
  endtask

  task automatic wait_valid_pc(input logic [31:0] exp_a, input string tag);
    int t = 0;
    while (!InstrValidF && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(tag, PCF, exp_a);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem.mem_req), 32'd0);
    check("rst_valid", 32'(InstrValidF), 32'd0);
    check("rst_fetchstall", 32'(FetchStall), 32'd1);
    check("rst_instr", InstrF, NOP_INSTR);
    check("rst_pcf", PCF, 32'd0);
    check("rst_pcplus4", PCPlus4F, 32'd4);

    // Zero-wait streaming from RESET_PC
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("c0_mem_req", 32'(mem.mem_req), 32'd0);
    @(negedge clk);
    check("c1_mem_req", 32'(mem.mem_req), 32'd1);
    check("c1_mem_addr", mem.mem_addr, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(InstrValidF), 32'd1);
      check("stream_pcf", PCF, 32'(k * 4));
    end
    repeat (10) @(negedge clk);

    // 3-cycle memory with decode stalled: fill, go idle, then drain
    lat    = 3;
    StallD = 1'b1;
    do_reset();
    repeat (40) @(negedge clk);
    check("full_valid", 32'(InstrValidF), 32'd1);
    check("full_head_pc", PCF, 32'd0);
    check("full_count", 32'(sb.size()), 32'(DEPTH));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_mem_req", 32'(mem.mem_req), 32'd0);
      check("full_hold_pc", PCF, 32'd0);
    end
    @(posedge clk);
    #1;
    StallD = 1'b0;
    repeat (60) @(negedge clk);
    check("resume_progress", 32'(exp_pc > 32'h40), 32'd1);

    // Redirect while a request to 0x20 is outstanding
    lat = 2;
    do_reset();
    wait_addr(32'h20, "wait_0x20_timeout");
    @(posedge clk);
    #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    @(posedge clk);
    #1;
    PCSrcE = 1'b0;
    @(negedge clk);
    wait_addr_change(32'h20, 32'h100, "discard_next_addr");
    wait_valid_pc(32'h100, "discard_first_pc");
    repeat (10) @(negedge clk);

    // Two redirects while discarding: only the last target is fetched
    lat = 3;
    begin
      logic [31:0] old_a;
      int t = 0;
      while (!req_new && t < 30) begin
        @(negedge clk);
        t++;
      end
      if (!req_new) check("wait_req_timeout", 32'd0, 32'd1);
      old_a = mem.mem_addr;
      @(posedge clk);
      #1;
      PCSrcE    = 1'b1;
      PCTargetE = 32'h100;
      @(posedge clk);
      #1;
      PCTargetE = 32'h200;
      @(posedge clk);
      #1;
      PCSrcE = 1'b0;
      @(negedge clk);
      wait_addr_change(old_a, 32'h200, "double_redirect_addr");
      wait_valid_pc(32'h200, "double_redirect_pc");
    end
    repeat (10) @(negedge clk);

    // Redirect coincident with ack and pop on a non-empty FIFO
    lat = 0;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h300;
    @(negedge clk);
    check("coinc_pre_valid", 32'(InstrValidF), 32'd1);
    check("coinc_pre_ack", 32'(mem.mem_ack), 32'd1);
    @(posedge clk);
    #1;
    PCSrcE = 1'b0;
    @(negedge clk);
    check("coinc_valid", 32'(InstrValidF), 32'd0);
    check("coinc_mem_req", 32'(mem.mem_req), 32'd1);
    check("coinc_mem_addr", mem.mem_addr, 32'h300);
    @(negedge clk);
    check("coinc_first_valid", 32'(InstrValidF), 32'd1);
    check("coinc_first_pc", PCF, 32'h300);
    repeat (8) @(negedge clk);

    // Reset mid-request, then a stale ack that must not push
    lat = 5;
    begin
      int t = 0;
      while (!req_new && t < 30) begin
        @(negedge clk);
        t++;
      end
      if (!req_new) check("wait_req5_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_en    = 1'b0;
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    check("rstmid_mem_req", 32'(mem.mem_req), 32'd0);
    check("rstmid_valid", 32'(InstrValidF), 32'd0);
    check("rstmid_instr", InstrF, NOP_INSTR);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("stale_ack_valid1", 32'(InstrValidF), 32'd0);
    check("stale_mem_req", 32'(mem.mem_req), 32'd1);
    @(negedge clk);
    check("stale_ack_valid2", 32'(InstrValidF), 32'd0);
    @(posedge clk);
    #1;
    mem_en = 1'b1;
    @(negedge clk);
    wait_valid_pc(32'd0, "after_reset_first_pc");
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
